// File: rtl/signed_sat_acc_pkg.sv
// Shared types and a reference saturating-add helper for the signed
// saturating frame accumulator.
package signed_sat_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   // Adds two signed values one bit wider than acc_w, then clamps the result
   // to the acc_w-bit two's complement range.
   function automatic int sat_add_f(input int a, input int b, input int acc_w,
                                    output bit clamped);
      int wide;
      int max_v;
      int min_v;
      wide  = a + b;
      max_v = (1 << (acc_w - 1)) - 1;
      min_v = -(1 << (acc_w - 1));
      clamped = 1'b0;
      if (wide > max_v) begin
         clamped = 1'b1;
         wide    = max_v;
      end else if (wide < min_v) begin
         clamped = 1'b1;
         wide    = min_v;
      end
      return wide;
   endfunction

endpackage

// File: rtl/signed_sat_accumulator_sat_add.sv
// Combinational signed saturating adder, ACC_W bits in and out.
module sat_add_param #(
   parameter int ACC_W = 8
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             clamped
);

   localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] wide;

   // Overflow shows up as disagreement between the two top bits of the
   // one-bit-wider sum; the extra sign bit tells which rail to clamp to.
   always_comb begin
      wide    = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      clamped = wide[ACC_W] ^ wide[ACC_W-1];
      sum     = wide[ACC_W-1:0];
      if (clamped) begin
         sum = wide[ACC_W] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Signed saturating frame accumulator: sums N_SAMPLES signed samples per
// frame and hands the clamped total downstream over valid/ready.
// Optional synchronous clear input enabled by macro SIGNED_SAT_ACC_CLEAR_EN.
//
// state | meaning
// ACCUM | accepting samples, building the frame sum
// DONE  | result presented, waiting for out_ready
module signed_sat_accumulator
   import signed_sat_acc_pkg::*;
#(
   parameter int W         = 4,
   parameter int ACC_W     = 8,
   parameter int N_SAMPLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef SIGNED_SAT_ACC_CLEAR_EN
   input  logic             clear,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_sat
);

   localparam int CNT_W = $clog2(N_SAMPLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

   state_t                  state;
   logic [ACC_W-1:0]        acc;
   logic [CNT_W-1:0]        cnt;
   logic                    sat;
   logic signed [ACC_W-1:0] x_ext;
   logic [ACC_W-1:0]        sum;
   logic                    clamped;
   logic                    clr;

`ifdef SIGNED_SAT_ACC_CLEAR_EN
   assign clr = clear;
`else
   assign clr = 1'b0;
`endif

   assign x_ext    = ACC_W'($signed(in_data));
   // A clear cycle never consumes a sample.
   assign in_ready = (state == ACCUM) && !clr;

   sat_add_param #(.ACC_W(ACC_W)) u_sat_add (
      .a       (acc),
      .b       (x_ext),
      .sum     (sum),
      .clamped (clamped)
   );

   // Frame FSM, sample counter, accumulator and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (clr) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  if (cnt == LAST_CNT) begin
                     out_data  <= sum;
                     out_sat   <= sat | clamped;
                     out_valid <= 1'b1;
                     state     <= DONE;
                     acc       <= '0;
                     cnt       <= '0;
                     sat       <= 1'b0;
                  end else begin
                     acc <= sum;
                     cnt <= cnt + 1'b1;
                     sat <= sat | clamped;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator: two instances (ACC_W=8 and ACC_W=5)
// driven in lockstep, results checked against a queued reference model.
// Build with SIGNED_SAT_ACC_CLEAR_EN defined to also exercise clear.
module tb_signed_sat_accumulator;
   import signed_sat_acc_pkg::*;

   typedef struct {
      int data;
      bit sat;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [3:0] in_data;
   logic       out_ready;

   logic       in_ready8, out_valid8, out_sat8;
   logic [7:0] out_data8;
   logic       in_ready5, out_valid5, out_sat5;
   logic [4:0] out_data5;

   int   vectors = 0;
   int   errs    = 0;
   exp_t exp8[$];
   exp_t exp5[$];
   int   m_acc8, m_acc5, m_cnt;
   bit   m_sat8, m_sat5;
   logic prev8, prev5;

   signed_sat_accumulator #(.W(4), .ACC_W(8), .N_SAMPLES(4)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SIGNED_SAT_ACC_CLEAR_EN
      .clear     (clear),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready8),
      .in_data   (in_data),
      .out_valid (out_valid8),
      .out_ready (out_ready),
      .out_data  (out_data8),
      .out_sat   (out_sat8)
   );

   signed_sat_accumulator #(.W(4), .ACC_W(5), .N_SAMPLES(4)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SIGNED_SAT_ACC_CLEAR_EN
      .clear     (clear),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready5),
      .in_data   (in_data),
      .out_valid (out_valid5),
      .out_ready (out_ready),
      .out_data  (out_data5),
      .out_sat   (out_sat5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errs++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_acc8 = 0; m_acc5 = 0; m_cnt = 0; m_sat8 = 0; m_sat5 = 0;
   endtask

   task automatic model_accept(input int v);
      bit c8, c5;
      m_acc8 = sat_add_f(m_acc8, v, 8, c8);
      m_acc5 = sat_add_f(m_acc5, v, 5, c5);
      m_sat8 = m_sat8 | c8;
      m_sat5 = m_sat5 | c5;
      if (m_cnt == 3) begin
         exp8.push_back('{data: m_acc8, sat: m_sat8});
         exp5.push_back('{data: m_acc5, sat: m_sat5});
         model_reset();
      end else begin
         m_cnt++;
      end
   endtask

   // Compares each result once, on the cycle its out_valid first rises.
   task automatic scan_out();
      exp_t e;
      if (out_valid8 && !prev8) begin
         check("q8_nonempty", int'(exp8.size() > 0), 1);
         if (exp8.size() > 0) begin
            e = exp8.pop_front();
            check("data8", int'($signed(out_data8)), e.data);
            check("sat8", int'(out_sat8), int'(e.sat));
         end
      end
      if (out_valid5 && !prev5) begin
         check("q5_nonempty", int'(exp5.size() > 0), 1);
         if (exp5.size() > 0) begin
            e = exp5.pop_front();
            check("data5", int'($signed(out_data5)), e.data);
            check("sat5", int'(out_sat5), int'(e.sat));
         end
      end
      prev8 = out_valid8;
      prev5 = out_valid5;
   endtask

   task automatic cyc();
      @(negedge clk);
      scan_out();
   endtask

   // Called at a negedge; returns at the negedge after the sample is taken.
   task automatic send(input int v);
      int n = 0;
      in_valid = 1'b1;
      in_data  = 4'(v);
      while (!in_ready8 && n < 50) begin
         cyc();
         n++;
      end
      check("send_timeout", int'(n < 50), 1);
      if (n < 50) model_accept(v);
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic send4(input int a, input int b, input int c, input int d);
      send(a); send(b); send(c); send(d);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      prev8 = 1'b0; prev5 = 1'b0;
      model_reset();
      cyc(); cyc();
      check("rst_valid8", int'(out_valid8), 0);
      check("rst_data8", int'(out_data8), 0);
      check("rst_sat5", int'(out_sat5), 0);
      rst_n = 1'b1;
      cyc();
      check("rst_in_ready", int'(in_ready8), 1);

      // Plain sum, then latency: result visible right after 4th accept.
      send4(1, 2, 3, 4);
      check("t1_latency", int'(out_valid8), 1);
      check("t1_in_ready_done", int'(in_ready8), 0);
      cyc();
      check("t1_back_accum", int'(in_ready8), 1);

      // Positive clamp then move back off the rail (non-sticky).
      send4(7, 7, 7, -8);
      cyc();
      // Negative rail.
      send4(-8, -8, -8, -8);
      cyc();
      // Sat flag must not leak into the next frame.
      send4(0, 0, 0, 0);
      cyc();

      // Backpressure: result held, in_valid ignored while DONE.
      out_ready = 1'b0;
      send4(1, 1, 1, 1);
      in_valid = 1'b1; in_data = 4'(5);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t4_hold_valid", int'(out_valid8), 1);
         check("t4_hold_data", int'($signed(out_data8)), 4);
         check("t4_hold_sat", int'(out_sat5), 0);
         check("t4_in_ready", int'(in_ready5), 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      cyc();
      check("t4_released", int'(out_valid8), 0);
      check("t4_in_ready_back", int'(in_ready8), 1);
      send4(2, 2, 2, 2);
      cyc();

      // Async reset mid-frame: outputs clear at once, partial frame lost.
      send(3); send(3);
      rst_n = 1'b0;
      #1;
      check("t5_rst_data8", int'(out_data8), 0);
      check("t5_rst_valid", int'(out_valid8), 0);
      model_reset();
      cyc();
      rst_n = 1'b1;
      cyc();
      send4(1, 1, 1, 1);
      cyc();

`ifdef SIGNED_SAT_ACC_CLEAR_EN
      out_ready = 1'b0;
      send4(2, 1, 1, 1);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      check("t6_clr_valid", int'(out_valid8), 0);
      check("t6_clr_data_kept", int'($signed(out_data8)), 5);
      out_ready = 1'b1;
      send(2); send(2);
      in_valid = 1'b1; in_data = 4'(7); clear = 1'b1;
      #1;
      check("t6_clr_in_ready", int'(in_ready8), 0);
      cyc();
      clear = 1'b0; in_valid = 1'b0;
      model_reset();
      send4(1, 1, 1, 1);
      cyc();
`endif

      check("q8_drained", exp8.size(), 0);
      check("q5_drained", exp5.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
